// File: rtl/clkdiv_pkg.sv
// Shared divisor type and helpers for the clkdiv_bank channels.
package clkdiv_pkg;

    localparam int DIV_W_DEF = 8;

    typedef logic [DIV_W_DEF-1:0] div_t;

    localparam div_t DIV_DISABLED = '0;

    // ceil(d/2) without widening: odd divisors get the extra high cycle.
    function automatic div_t half_hi(input div_t d);
        return (d >> 1) + div_t'(d[0]);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: a period counter with a pending divisor that is swapped in only at a period boundary.
// With CLKDIV_SYNC_EN defined, sync_i forces a boundary on every enabled channel.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DEF_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  div_t value_i,
    input  logic sync_i,
    output logic pend_o,
    output logic clk_o,
    output logic tick_o
);

    localparam div_t DEF_VAL  = div_t'(DEF_DIV);
    localparam div_t DEF_LAST = div_t'(DEF_DIV - 1);

    div_t count_q, count_d;
    div_t div_q, div_d;
    div_t pend_val_q, pend_val_d;
    logic pend_q, pend_d;
    logic clk_q, clk_d;
    logic tick_q, tick_d;
    logic wrap;
    div_t hi;

`ifdef CLKDIV_SYNC_EN
    assign wrap = (count_q == div_q - div_t'(1)) || sync_i;
`else
    logic unused_sync;
    assign unused_sync = sync_i;
    assign wrap = (count_q == div_q - div_t'(1));
`endif

    assign hi = half_hi(div_q);

    always_comb begin
        count_d    = count_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        clk_d      = 1'b0;
        tick_d     = 1'b0;
        if (div_q == DIV_DISABLED) begin
            // Preload count to the last slot so the following edge opens a fresh period.
            if (pend_q) begin
                div_d   = pend_val_q;
                pend_d  = 1'b0;
                count_d = (pend_val_q == DIV_DISABLED) ? '0 : pend_val_q - div_t'(1);
            end
        end else if (wrap) begin
            if (pend_q) begin
                div_d  = pend_val_q;
                pend_d = 1'b0;
            end
            count_d = '0;
            clk_d   = (div_d != DIV_DISABLED);
            tick_d  = (div_d != DIV_DISABLED);
        end else begin
            count_d = count_q + div_t'(1);
            clk_d   = (count_d < hi);
        end
        if (load_i) begin
            pend_d     = 1'b1;
            pend_val_d = (value_i == div_t'(1)) ? div_t'(2) : value_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q    <= DEF_LAST;
            div_q      <= DEF_VAL;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clkdiv_bank.sv
// CH independent clock dividers with runtime-reprogrammable divisors and a shared write port.
// Optional phase realignment via sync_i is built in only when CLKDIV_SYNC_EN is defined.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 25,
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk100mhz,
    input  logic             rst_n,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [CW-1:0]    div_chan,
    input  logic [DIV_W-1:0] div_value,
    input  logic             sync_i,
    output logic [CH-1:0]    clk_o,
    output logic [CH-1:0]    tick_o
);

    logic [CH-1:0] pend_vec;
    logic          in_range;

    // Out-of-range channels always accept so a stray write can never stall the port.
    assign in_range  = int'(div_chan) < CH;
    assign div_ready = in_range ? !pend_vec[div_chan] : 1'b1;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        logic load;
        assign load = div_valid && div_ready && (int'(div_chan) == gi);

        clkdiv_chan #(
            .DEF_DIV(DEF_DIV)
        ) u_chan (
            .clk_i  (clk100mhz),
            .rst_ni (rst_n),
            .load_i (load),
            .value_i(div_t'(div_value)),
            .sync_i (sync_i),
            .pend_o (pend_vec[gi]),
            .clk_o  (clk_o[gi]),
            .tick_o (tick_o[gi])
        );
    end

endmodule
